// File: rtl/ts_deframer_pkg.sv
// Shared symbol codes, error codes and helpers for the TS receive deframer.
package ts_deframer_pkg;

    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PADG12    = 8'hF7;
    localparam logic [7:0] TS1_IDTFR = 8'h4A;
    localparam logic [7:0] TS2_IDTFR = 8'h45;

    localparam logic [1:0] ERR_EARLY_COM = 2'd1;
    localparam logic [1:0] ERR_BAD_ID    = 2'd2;
    localparam logic [1:0] ERR_GAP       = 2'd3;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // True when every byte of the 10-symbol identifier field equals id.
    function automatic logic id_match(input logic [79:0] ids, input logic [7:0] id);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (ids[8*i +: 8] != id) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/ts_lock_mon.sv
// Symbol-lock monitor: saturating good/bad set counters driving a lock flag.
module ts_lock_mon #(
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic good_set,
    input  logic err_set,
    output logic locked
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);

    logic [GW-1:0] good_cnt, good_nxt;
    logic [BW-1:0] bad_cnt, bad_nxt;
    logic          locked_nxt;

    always_comb begin
        good_nxt   = good_cnt;
        bad_nxt    = bad_cnt;
        locked_nxt = locked;
        if (flush) begin
            good_nxt   = '0;
            bad_nxt    = '0;
            locked_nxt = 1'b0;
        end else if (good_set) begin
            if (good_cnt != GW'(LOCK_CNT)) begin
                good_nxt = good_cnt + GW'(1);
            end
            bad_nxt = '0;
            if (good_nxt == GW'(LOCK_CNT)) begin
                locked_nxt = 1'b1;
            end
        end else if (err_set) begin
            if (bad_cnt != BW'(UNLOCK_CNT)) begin
                bad_nxt = bad_cnt + BW'(1);
            end
            good_nxt = '0;
            if (bad_nxt == BW'(UNLOCK_CNT)) begin
                locked_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            locked   <= 1'b0;
        end else begin
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            locked   <= locked_nxt;
        end
    end

endmodule

// File: rtl/ts_deframer.sv
// Receive-side TS1/TS2 deframer: COM alignment, 16-symbol assembly, identifier check.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_HUNT    | waiting for COM, all other symbols dropped
// ST_COLLECT | COM held in buf[0], collecting symbols 1..15 at idx
module ts_deframer
    import ts_deframer_pkg::*;
#(
    parameter int GAP_MAX    = 8,
    parameter int LOCK_CNT   = 2,
    parameter int UNLOCK_CNT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_flush,
    input  logic [7:0]   rx_sym,
    input  logic         rx_sym_vld,
    output logic [127:0] remote_ts,
    output logic         remote_ts_valid,
    output logic         remote_ts_type,
    output logic         rx_err,
    output logic [1:0]   rx_err_code,
    output logic         rx_locked
);

    localparam int GAP_W = $clog2(GAP_MAX + 1);

    state_t           state, state_nxt;
    logic [3:0]       idx, idx_nxt;
    logic [GAP_W-1:0] gap, gap_nxt;
    // Symbols 0..14; symbol 15 is taken straight from rx_sym when the set completes.
    logic [119:0]     sym_buf, buf_nxt;
    logic [127:0]     ts_word;
    logic [79:0]      id_field;
    logic             good_set, err_set, type_nxt;
    logic [1:0]       err_code_nxt;

    assign ts_word  = {sym_buf, rx_sym};
    assign id_field = {sym_buf[71:0], rx_sym};

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        gap_nxt      = gap;
        buf_nxt      = sym_buf;
        good_set     = 1'b0;
        err_set      = 1'b0;
        err_code_nxt = rx_err_code;
        type_nxt     = remote_ts_type;

        if (rx_flush) begin
            state_nxt = ST_HUNT;
            idx_nxt   = '0;
            gap_nxt   = '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (rx_sym_vld && rx_sym == COM) begin
                        buf_nxt[119:112] = COM;
                        idx_nxt          = 4'd1;
                        gap_nxt          = '0;
                        state_nxt        = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (rx_sym_vld) begin
                        gap_nxt = '0;
                        if (rx_sym == COM) begin
                            // Realign on the new COM so back-to-back sets lose nothing.
                            err_set          = 1'b1;
                            err_code_nxt     = ERR_EARLY_COM;
                            buf_nxt[119:112] = COM;
                            idx_nxt          = 4'd1;
                        end else if (idx == 4'd15) begin
                            state_nxt = ST_HUNT;
                            idx_nxt   = '0;
                            if (id_match(id_field, TS1_IDTFR)) begin
                                good_set = 1'b1;
                                type_nxt = 1'b0;
                            end else if (id_match(id_field, TS2_IDTFR)) begin
                                good_set = 1'b1;
                                type_nxt = 1'b1;
                            end else begin
                                err_set      = 1'b1;
                                err_code_nxt = ERR_BAD_ID;
                            end
                        end else begin
                            buf_nxt[8*(14 - int'(idx)) +: 8] = rx_sym;
                            idx_nxt = idx + 4'd1;
                        end
                    end else if (gap == GAP_W'(GAP_MAX - 1)) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_GAP;
                        state_nxt    = ST_HUNT;
                        idx_nxt      = '0;
                        gap_nxt      = '0;
                    end else begin
                        gap_nxt = gap + GAP_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_HUNT;
                    idx_nxt   = '0;
                    gap_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_HUNT;
            idx             <= '0;
            gap             <= '0;
            sym_buf         <= '0;
            remote_ts       <= '0;
            remote_ts_valid <= 1'b0;
            remote_ts_type  <= 1'b0;
            rx_err          <= 1'b0;
            rx_err_code     <= '0;
        end else begin
            state           <= state_nxt;
            idx             <= idx_nxt;
            gap             <= gap_nxt;
            sym_buf         <= buf_nxt;
            remote_ts_valid <= good_set;
            rx_err          <= err_set;
            rx_err_code     <= err_code_nxt;
            remote_ts_type  <= type_nxt;
            if (good_set) begin
                remote_ts <= ts_word;
            end
        end
    end

    ts_lock_mon #(
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_mon (
        .clk      (clk),
        .rst      (rst),
        .flush    (rx_flush),
        .good_set (good_set),
        .err_set  (err_set),
        .locked   (rx_locked)
    );

endmodule

// File: doc/ts_deframer.md
Name: ts_deframer

Overview:
- Receive-side deframer that sits directly upstream of the TS analyzer.
- Takes the per-lane received symbol stream one byte at a time, aligns on COM and assembles 16-symbol TS1/TS2 ordered sets.
- Validates the identifier field and delivers each good set as one 128-bit word with a single-cycle valid (remote_ts / remote_ts_valid) to the analyzer.
- Reports malformed sets and a symbol-lock status.

Parameters:
- GAP_MAX, 8, max consecutive idle cycles (rx_sym_vld low) tolerated inside one set before abort
- LOCK_CNT, 2, consecutive good sets needed to assert rx_locked
- UNLOCK_CNT, 4, consecutive errored sets needed to drop rx_locked

Ports:
- clk  in  1  1GHz system clock
- rst  in  1  reset; asynchronous, active-high
- rx_flush  in  1  synchronous flush (state change / electrical idle)
- rx_sym  in  8  received symbol
- rx_sym_vld  in  1  rx_sym valid this cycle
- remote_ts  out  128  assembled set; symbol0 at [127:120], symbol15 at [7:0]
- remote_ts_valid  out  1  one-cycle pulse, remote_ts good
- remote_ts_type  out  1  0=TS1, 1=TS2; qualified by remote_ts_valid
- rx_err  out  1  one-cycle pulse, malformed set discarded
- rx_err_code  out  2  1=early COM, 2=bad identifier, 3=gap timeout; held until next rx_err
- rx_locked  out  1  symbol lock status

Behaviour:
- Reset: all outputs 0, state HUNT, idx=0, gap/good/bad counters 0, symbol buffer 0.
- All outputs registered. Symbols are consumed only when rx_sym_vld=1.
- HUNT:
  - rx_sym_vld and rx_sym==`COM (8'hBC): buf[0]<=COM, idx<=1, go COLLECT.
  - Other symbols are dropped silently.
- COLLECT, rx_sym_vld=1:
  - gap<=0.
  - rx_sym==`COM at idx 1..15: rx_err pulse, code 1. The new COM becomes buf[0], idx<=1, stay COLLECT (realign, no symbol lost).
  - Otherwise buf[idx]<=rx_sym, idx<=idx+1.
  - At idx==15, after storing, check buf[6..15]:
    - All equal `TS1_IDTFR (8'h4A) or all equal `TS2_IDTFR (8'h45): next cycle remote_ts_valid=1, remote_ts=assembled word, remote_ts_type set.
    - Otherwise rx_err pulse, code 2.
    - Either way go HUNT.
  - Symbols 1..5 (link, lane, N_FTS, rate, control) are not checked; that is the analyzer's job.
- COLLECT, rx_sym_vld=0:
  - gap<=gap+1.
  - When gap reaches GAP_MAX: rx_err pulse, code 3, go HUNT, idx<=0.
- Latency: remote_ts_valid asserts exactly 1 cycle after the cycle symbol15 is accepted.
- Back-to-back: a COM in the cycle right after symbol15 must be captured. Zero dead cycles between sets.
- remote_ts and remote_ts_type hold their last good value between pulses. They are never updated on error.
- Lock:
  - Good set: good<=min(good+1, LOCK_CNT), bad<=0.
  - Error (any code): bad<=min(bad+1, UNLOCK_CNT), good<=0.
  - rx_locked sets when good reaches LOCK_CNT and clears when bad reaches UNLOCK_CNT. Both update in the same cycle as the valid/err pulse.
- rx_flush: highest priority. Next cycle state=HUNT, idx/gap/good/bad=0, rx_locked=0, no rx_err. The in-progress set is discarded. remote_ts retains its value. A COM arriving together with rx_flush is ignored.
- Reset mid-set: immediate return to the reset values above. No output pulse is produced.
- remote_ts_valid and rx_err are never high in the same cycle.

Decomposition:
- Shared define package: `COM, `PADG12, `TS1_IDTFR, `TS2_IDTFR, and the error-code constants ERR_EARLY_COM=2'd1, ERR_BAD_ID=2'd2, ERR_GAP=2'd3.
- Main module: ts_deframer, holding the FSM and the symbol buffer.
- One natural sub-module, ts_lock_mon: good/bad saturating counters plus rx_locked. Inputs are the good/err pulses; reusable for later multi-lane deskew.

Test Plan:
- Good TS1: BC,F7,F7,FF,06,00, then 4A x10, contiguous → remote_ts_valid 1 cycle after last symbol; remote_ts=128'hBCF7F7FF0600_4A4A…4A; type=0; no rx_err.
- Two back-to-back TS2 (ID 45) → two pulses exactly 16 cycles apart; rx_locked=1 on the second pulse.
- TS1 with symbol9=4B → rx_err, code=2, no valid, remote_ts unchanged. After 4 such sets while locked, rx_locked=0.
- COM injected at idx 7, followed by a full good TS1 body → rx_err code=1, then valid for the realigned set 16 symbols after the injected COM.
- 8 idle cycles after symbol5 → rx_err code=3. A trailing body without COM produces nothing. The next complete TS decodes normally.
- rx_flush asserted at idx 10 while locked → rx_locked=0 next cycle, no pulses, the following good TS1 decodes. Async rst mid-set → all outputs 0 immediately.
